ber_checker: RTL and testbench

BER_CHECKER -- requirements
Module: ber_checker

---
 rtl/ber_checker.sv | 160 ++++++++++++++++
 tb/tb_ber_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker.sv
// PN-sequence bit-error-rate checker: self-synchronises an LFSR to the received
// stream, then counts compared bits and errors while locked.
module ber_checker #(
   parameter int unsigned       LFSR_W   = 7,
   parameter logic [LFSR_W-1:0] TAPS     = 7'b1100000,
   parameter int unsigned       LOCK_CNT = 16,
   parameter int unsigned       WIN      = 64,
   parameter int unsigned       LOSS_THR = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bit_en,
   input  logic        data_i,
   input  logic        clear,
   output logic        locked,
   output logic [1:0]  state_o,
   output logic        err_o,
   output logic [31:0] bit_cnt,
   output logic [31:0] err_cnt
);

   localparam int unsigned FillW  = $clog2(LFSR_W + 1);
   localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
   localparam int unsigned WinW   = $clog2(WIN + 1);
   localparam int unsigned WerrW  = $clog2(LOSS_THR + 1);

   typedef enum logic [1:0] {
      StHunt   = 2'd0,
      StVerify = 2'd1,
      StLocked = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [LFSR_W-1:0] reg_q, reg_d;
   logic [FillW-1:0]  fill_q, fill_d;
   logic [MatchW-1:0] match_q, match_d;
   logic [WinW-1:0]   win_bit_q, win_bit_d;
   logic [WerrW-1:0]  win_err_q, win_err_d;
   logic [WerrW-1:0]  win_err_nxt;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic [31:0]       bit_cnt_q, bit_cnt_d;
   logic [31:0]       err_cnt_q, err_cnt_d;
   logic              pred;
   logic              mism;
   logic              cnt_inc;

   assign pred = ^(reg_q & TAPS);
   assign mism = data_i ^ pred;

   always_comb begin
      state_d     = state_q;
      reg_d       = reg_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_bit_d   = win_bit_q;
      win_err_d   = win_err_q;
      win_err_nxt = win_err_q + WerrW'(mism);
      err_d       = 1'b0;
      cnt_inc     = 1'b0;
      if (bit_en) begin
         unique case (state_q)
            StHunt: begin
               reg_d = {reg_q[LFSR_W-2:0], data_i};
               if (fill_q == FillW'(LFSR_W - 1)) begin
                  fill_d = '0;
                  // An all-zero fill would lock the LFSR at zero, so refill instead.
                  if (reg_d != '0) begin
                     state_d = StVerify;
                     match_d = '0;
                  end
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
            StVerify: begin
               reg_d = {reg_q[LFSR_W-2:0], pred};
               if (!mism) begin
                  if (match_q == MatchW'(LOCK_CNT - 1)) begin
                     state_d   = StLocked;
                     match_d   = '0;
                     win_bit_d = '0;
                     win_err_d = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  state_d = StHunt;
                  fill_d  = '0;
               end
            end
            StLocked: begin
               reg_d   = {reg_q[LFSR_W-2:0], pred};
               cnt_inc = 1'b1;
               err_d   = mism;
               if (win_err_nxt == WerrW'(LOSS_THR)) begin
                  state_d   = StHunt;
                  fill_d    = '0;
                  win_bit_d = '0;
                  win_err_d = '0;
               end else if (win_bit_q == WinW'(WIN - 1)) begin
                  win_bit_d = '0;
                  win_err_d = '0;
               end else begin
                  win_bit_d = win_bit_q + 1'b1;
                  win_err_d = win_err_nxt;
               end
            end
            default: state_d = StHunt;
         endcase
      end
      locked_d = (state_d == StLocked);
   end

   // Clear has priority over counting; both counters saturate at all-ones.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      err_cnt_d = err_cnt_q;
      if (clear) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end else begin
         if (cnt_inc && (bit_cnt_q != '1)) bit_cnt_d = bit_cnt_q + 1'b1;
         if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StHunt;
         reg_q     <= '0;
         fill_q    <= '0;
         match_q   <= '0;
         win_bit_q <= '0;
         win_err_q <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         bit_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         reg_q     <= reg_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         win_bit_q <= win_bit_d;
         win_err_q <= win_err_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         bit_cnt_q <= bit_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign locked  = locked_q;
   assign state_o = state_q;
   assign err_o   = err_q;
   assign bit_cnt = bit_cnt_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: table of PN-stream phases plus hand-written
// sequences for verify-slip, clear at lock entry, mid-lock reset, saturation and zero input.
module tb_ber_checker;

   logic        clk;
   logic        reset;
   logic        bit_en;
   logic        data_i;
   logic        clear;
   logic        locked;
   logic [1:0]  state_o;
   logic        err_o;
   logic [31:0] bit_cnt;
   logic [31:0] err_cnt;

   int          n_tests;
   int          n_fail;
   logic [6:0]  gen_q;

   ber_checker dut (
      .clk     (clk),
      .reset   (reset),
      .bit_en  (bit_en),
      .data_i  (data_i),
      .clear   (clear),
      .locked  (locked),
      .state_o (state_o),
      .err_o   (err_o),
      .bit_cnt (bit_cnt),
      .err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          nbits;
      int          flip_per;
      bit          clr_first;
      logic [1:0]  st;
      logic [31:0] bits;
      logic [31:0] errs;
      int          pulses;
   } row_t;

   row_t rows[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // PN7 reference, x^7+x^6+1.
   task automatic next_pn(output logic b);
      b     = gen_q[6] ^ gen_q[5];
      gen_q = {gen_q[5:0], b};
   endtask

   // One strobed bit followed by idle cycles; e is err_o in the cycle after the strobe.
   task automatic send(input logic b, input logic clr, output logic e);
      @(negedge clk);
      bit_en = 1'b1;
      data_i = b;
      clear  = clr;
      @(negedge clk);
      bit_en = 1'b0;
      clear  = 1'b0;
      e      = err_o;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_pn(input logic flip, input logic clr, output logic e);
      logic b;
      next_pn(b);
      send(b ^ flip, clr, e);
   endtask

   task automatic send_clean(input int n);
      logic e;
      for (int i = 0; i < n; i++) send_pn(1'b0, 1'b0, e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      gen_q = 7'h7F;
   endtask

   initial begin
      logic e;
      int   pulses;
      bit   left_hunt;

      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      bit_en  = 1'b0;
      data_i  = 1'b0;
      clear   = 1'b0;
      gen_q   = 7'h7F;

      //          nbits flip clr st    bits  errs pulses
      rows[0] = '{22,   0,   0, 2'd1, 0,    0,   0};
      rows[1] = '{1,    0,   0, 2'd2, 0,    0,   0};
      rows[2] = '{1000, 0,   0, 2'd2, 1000, 0,   0};
      rows[3] = '{100,  10,  0, 2'd2, 1100, 10,  10};
      rows[4] = '{20,   0,   1, 2'd2, 19,   0,   0};
      rows[5] = '{40,   0,   0, 2'd2, 59,   0,   0};
      rows[6] = '{7,    1,   0, 2'd2, 66,   7,   7};
      rows[7] = '{1,    1,   0, 2'd0, 67,   8,   1};
      rows[8] = '{22,   0,   0, 2'd1, 67,   8,   0};
      rows[9] = '{1,    0,   0, 2'd2, 67,   8,   0};

      repeat (3) @(negedge clk);
      chk("rst_state", {30'd0, state_o}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_err_o", {31'd0, err_o}, 32'd0);
      chk("rst_bit_cnt", bit_cnt, 32'd0);
      chk("rst_err_cnt", err_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int r = 0; r < 10; r++) begin
         pulses = 0;
         for (int j = 1; j <= rows[r].nbits; j++) begin
            send_pn((rows[r].flip_per != 0) && (j % rows[r].flip_per == 0),
                    rows[r].clr_first && (j == 1), e);
            if (e === 1'b1) pulses++;
         end
         chk($sformatf("row%0d_state", r), {30'd0, state_o}, {30'd0, rows[r].st});
         chk($sformatf("row%0d_locked", r), {31'd0, locked}, {31'd0, rows[r].st == 2'd2});
         chk($sformatf("row%0d_bit_cnt", r), bit_cnt, rows[r].bits);
         chk($sformatf("row%0d_err_cnt", r), err_cnt, rows[r].errs);
         chk($sformatf("row%0d_err_pulses", r), pulses, rows[r].pulses);
      end

      // Slip during verify at match count 10, then reacquire in 23 bits.
      do_reset();
      send_clean(17);
      chk("slip_pre_state", {30'd0, state_o}, 32'd1);
      send_pn(1'b1, 1'b0, e);
      chk("slip_state", {30'd0, state_o}, 32'd0);
      send_clean(22);
      chk("slip_22_locked", {31'd0, locked}, 32'd0);
      send_clean(1);
      chk("slip_23_locked", {31'd0, locked}, 32'd1);

      // Build counts, lose lock with 8 errors, then clear on the lock-entry bit.
      send_clean(10);
      for (int i = 0; i < 8; i++) send_pn(1'b1, 1'b0, e);
      chk("loss_state", {30'd0, state_o}, 32'd0);
      chk("loss_bit_cnt", bit_cnt, 32'd18);
      chk("loss_err_cnt", err_cnt, 32'd8);
      send_clean(22);
      send_pn(1'b0, 1'b1, e);
      chk("clr_lock_locked", {31'd0, locked}, 32'd1);
      chk("clr_lock_bit_cnt", bit_cnt, 32'd0);
      chk("clr_lock_err_cnt", err_cnt, 32'd0);
      send_clean(5);
      chk("clr_after_bit_cnt", bit_cnt, 32'd5);

      // Asynchronous reset while locked, sampled before the next clock edge.
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_state", {30'd0, state_o}, 32'd0);
      chk("async_rst_locked", {31'd0, locked}, 32'd0);
      chk("async_rst_bit_cnt", bit_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      gen_q = 7'h7F;
      send_clean(23);
      chk("relock_locked", {31'd0, locked}, 32'd1);
      repeat (3) @(negedge clk);
      chk("idle_err_o", {31'd0, err_o}, 32'd0);

      // Saturation, then clear wins over a simultaneous strobe.
      @(negedge clk);
      force dut.bit_cnt_q = 32'hFFFF_FFFE;
      #1 release dut.bit_cnt_q;
      send_clean(3);
      chk("sat_bit_cnt", bit_cnt, 32'hFFFF_FFFF);
      chk("sat_state", {30'd0, state_o}, 32'd2);
      send_pn(1'b0, 1'b1, e);
      chk("sat_clr_bit_cnt", bit_cnt, 32'd0);

      // All-zero input never leaves hunt.
      do_reset();
      left_hunt = 1'b0;
      for (int i = 0; i < 30; i++) begin
         send(1'b0, 1'b0, e);
         if ((state_o !== 2'd0) || (locked !== 1'b0)) left_hunt = 1'b1;
      end
      chk("zero_left_hunt", {31'd0, left_hunt}, 32'd0);
      chk("zero_state", {30'd0, state_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
